// File: rtl/gen1_scrambler_sched.sv
// Gen1/2 transmit scheduler ahead of the 32-bit lane scrambler: forwards packet words,
// fills gaps with logical idle and inserts SKP ordered sets at packet boundaries.
module gen1_scrambler_sched #(
  parameter int unsigned SKP_INTERVAL = 295,
  parameter int unsigned CNT_W        = 12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        link_active_i,
  input  logic        scramble_disable_i,
  input  logic        up_valid_i,
  output logic        up_ready_o,
  input  logic [31:0] up_data_i,
  input  logic [3:0]  up_datak_i,
  input  logic        up_last_i,
  input  logic        up_ts_i,
  output logic        scr_valid_o,
  output logic [31:0] scr_data_o,
  output logic [3:0]  scr_datak_o,
  output logic [3:0]  scr_training_sequence_o,
  output logic [1:0]  scr_data_len_o,
  output logic        scr_scramble_enable_o,
  output logic        scr_lfsr_reset_o,
  output logic        skp_sent_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);
  localparam logic [31:0]      SKP_WORD = 32'h1C1C_1CBC;
  localparam logic [1:0]       LEN_FULL = 2'b10;

  typedef enum logic [1:0] {OFF, PASS, SKP_PEND, SKP_SEND} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             in_packet, in_packet_n;
  logic             accept;

  logic        valid_n, scr_en_n, lfsr_reset_n, skp_sent_n;
  logic [31:0] data_n;
  logic [3:0]  datak_n, ts_n;
  logic [1:0]  len_n;

  assign up_ready_o = rst_ni & link_active_i
                    & ~((state == SKP_PEND) & ~in_packet)
                    & (state != SKP_SEND);
  assign accept  = up_valid_i & up_ready_o;
  assign cnt_inc = cnt + CNT_W'(1);

  // Next-state and next-output word selection
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    in_packet_n  = in_packet;
    valid_n      = 1'b0;
    data_n       = 32'h0;
    datak_n      = 4'h0;
    ts_n         = 4'h0;
    len_n        = 2'b00;
    scr_en_n     = 1'b0;
    lfsr_reset_n = 1'b0;
    skp_sent_n   = 1'b0;

    if (!link_active_i) begin
      state_n     = OFF;
      cnt_n       = '0;
      in_packet_n = 1'b0;
    end else begin
      valid_n  = 1'b1;
      len_n    = LEN_FULL;
      scr_en_n = ~scramble_disable_i;
      if (accept) begin
        in_packet_n  = ~up_last_i;
        data_n       = up_data_i;
        datak_n      = up_datak_i;
        ts_n         = {4{up_ts_i}} | up_datak_i;
        lfsr_reset_n = up_datak_i[0] & (up_data_i[7:0] == 8'hBC);
      end

      case (state)
        OFF, PASS: begin
          cnt_n   = cnt_inc;
          state_n = PASS;
          // SKP goes out right away when no packet is open, else waits for its last word
          if (cnt_inc >= CNT_LAST) begin
            cnt_n   = CNT_LAST;
            state_n = in_packet_n ? SKP_PEND : SKP_SEND;
          end
        end
        SKP_PEND: begin
          state_n = in_packet_n ? SKP_PEND : SKP_SEND;
        end
        SKP_SEND: begin
          data_n       = SKP_WORD;
          datak_n      = 4'hF;
          ts_n         = 4'hF;
          lfsr_reset_n = 1'b1;
          skp_sent_n   = 1'b1;
          cnt_n        = '0;
          state_n      = PASS;
        end
        default: state_n = OFF;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state                   <= OFF;
      cnt                     <= '0;
      in_packet               <= 1'b0;
      scr_valid_o             <= 1'b0;
      scr_data_o              <= 32'h0;
      scr_datak_o             <= 4'h0;
      scr_training_sequence_o <= 4'h0;
      scr_data_len_o          <= 2'b00;
      scr_scramble_enable_o   <= 1'b0;
      scr_lfsr_reset_o        <= 1'b0;
      skp_sent_o              <= 1'b0;
    end else begin
      state                   <= state_n;
      cnt                     <= cnt_n;
      in_packet               <= in_packet_n;
      scr_valid_o             <= valid_n;
      scr_data_o              <= data_n;
      scr_datak_o             <= datak_n;
      scr_training_sequence_o <= ts_n;
      scr_data_len_o          <= len_n;
      scr_scramble_enable_o   <= scr_en_n;
      scr_lfsr_reset_o        <= lfsr_reset_n;
      skp_sent_o              <= skp_sent_n;
    end
  end

endmodule

// File: tb/tb_gen1_scrambler_sched.sv
// Bench for gen1_scrambler_sched: directed phases plus random traffic, each cycle checked
// against a word-schedule model (words since last SKP, open packet, SKP owed).
module tb_gen1_scrambler_sched;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n, link, dis, valid, last, ts;
  logic [31:0] data;
  logic [3:0]  datak;

  logic        up_ready, scr_valid, scr_en, scr_lr, skp_sent;
  logic [31:0] scr_data;
  logic [3:0]  scr_k, scr_ts;
  logic [1:0]  scr_len;

  always #5 clk = ~clk;

  gen1_scrambler_sched #(.SKP_INTERVAL(N), .CNT_W(12)) dut (
    .clk_i(clk), .rst_ni(rst_n), .link_active_i(link), .scramble_disable_i(dis),
    .up_valid_i(valid), .up_ready_o(up_ready), .up_data_i(data), .up_datak_i(datak),
    .up_last_i(last), .up_ts_i(ts), .scr_valid_o(scr_valid), .scr_data_o(scr_data),
    .scr_datak_o(scr_k), .scr_training_sequence_o(scr_ts), .scr_data_len_o(scr_len),
    .scr_scramble_enable_o(scr_en), .scr_lfsr_reset_o(scr_lr), .skp_sent_o(skp_sent)
  );

  int checks = 0;
  int failures = 0;

  // Model: words emitted since the last SKP, whether a packet is open, whether a SKP is owed
  int          since;
  bit          open_pkt, skp_now, m_ready, acc;
  bit          e_valid, e_en, e_lr, e_skp;
  logic [31:0] e_data;
  logic [3:0]  e_k, e_ts;
  logic [1:0]  e_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict, check the combinational ready, then check registered outputs
  task automatic cyc();
    #2;
    if (!rst_n || !link) begin
      m_ready = 0; acc = 0;
      e_valid = 0; e_data = 0; e_k = 0; e_ts = 0; e_len = 0; e_en = 0; e_lr = 0; e_skp = 0;
      since = 0; open_pkt = 0; skp_now = 0;
    end else begin
      m_ready = !skp_now;
      acc = valid && m_ready;
      e_valid = 1; e_len = 2'b10; e_en = !dis;
      if (skp_now) begin
        e_data = 32'h1C1C1CBC; e_k = 4'hF; e_ts = 4'hF; e_lr = 1; e_skp = 1;
        since = 0; skp_now = 0;
      end else begin
        e_skp = 0;
        if (acc) begin
          e_data = data; e_k = datak; e_ts = {4{ts}} | datak;
          e_lr = datak[0] && (data[7:0] == 8'hBC);
          open_pkt = !last;
        end else begin
          e_data = 0; e_k = 0; e_ts = 0; e_lr = 0;
        end
        if (since < N - 1) since++;
        if (since == N - 1 && !open_pkt) skp_now = 1;
      end
    end
    chk("up_ready", 32'(up_ready), 32'(m_ready));
    @(posedge clk);
    #1;
    chk("scr_valid", 32'(scr_valid), 32'(e_valid));
    chk("scr_data", scr_data, e_data);
    chk("scr_datak", 32'(scr_k), 32'(e_k));
    chk("scr_ts", 32'(scr_ts), 32'(e_ts));
    chk("scr_len", 32'(scr_len), 32'(e_len));
    chk("scr_en", 32'(scr_en), 32'(e_en));
    chk("lfsr_reset", 32'(scr_lr), 32'(e_lr));
    chk("skp_sent", 32'(skp_sent), 32'(e_skp));
  endtask

  task automatic rand_word();
    data  = $urandom;
    datak = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    if ($urandom_range(0, 4) == 0) begin
      data[7:0] = 8'hBC;
      datak[0]  = 1'b1;
    end
    ts = ($urandom_range(0, 9) == 0);
  endtask

  // Sends words 0..stop-1 of a len-word packet; counts cycles a valid word was refused
  task automatic send_pkt(input int len, input int stop, input bit gaps, output int stalls);
    int guard;
    stalls = 0;
    for (int i = 0; i < stop; i++) begin
      rand_word();
      last = (i == len - 1);
      acc = 0;
      guard = 0;
      while (!acc && guard < 40) begin
        valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        cyc();
        if (valid && !acc) stalls++;
        guard++;
      end
      if (!acc) chk("send_timeout", 32'(0), 32'(1));
    end
    valid = 0;
    last  = 0;
  endtask

  task automatic wait_since(input int target);
    int guard = 0;
    valid = 0;
    while (since != target && guard < 3 * N) begin
      cyc();
      guard++;
    end
    chk("wait_since", 32'(since), 32'(target));
  endtask

  initial begin
    int stalls, prev, npulse, k, guard;
    bit holding;
    int wi, plen;

    rst_n = 0; link = 1; dis = 0; valid = 1; last = 0; ts = 0; data = 32'hDEADBEEF; datak = 4'h1;
    since = 0; open_pkt = 0; skp_now = 0;

    // Reset held with link active and upstream offering a word
    for (int i = 0; i < 3; i++) cyc();
    chk("reset_ready", 32'(up_ready), 32'(0));
    chk("reset_len", 32'(scr_len), 32'(0));

    // Release, no traffic: idle words then SKP every N words
    rst_n = 1; valid = 0; datak = 0; data = 0;
    cyc();
    chk("first_valid", 32'(scr_valid), 32'(1));
    chk("first_len", 32'(scr_len), 32'(2));
    prev = -1; npulse = 0;
    for (int i = 2; i <= 26; i++) begin
      cyc();
      if (skp_sent) begin
        chk("skp_word", scr_data, 32'h1C1C1CBC);
        if (prev >= 0) chk("skp_gap", 32'(i - prev), 32'(N));
        prev = i;
        npulse++;
      end
    end
    chk("skp_count", 32'(npulse >= 2), 32'(1));

    // Deferred SKP: 10-word packet starting at counter 5
    wait_since(5);
    send_pkt(10, 10, 1'b0, stalls);
    chk("deferred_in_pkt_stalls", 32'(stalls), 32'(0));
    send_pkt(1, 1, 1'b0, stalls);
    chk("deferred_after_stall", 32'(stalls), 32'(1));

    // Boundary collision: last word accepted as the counter reaches N-1
    wait_since(N - 4);
    send_pkt(3, 3, 1'b0, stalls);
    chk("collision_pkt_stalls", 32'(stalls), 32'(0));
    send_pkt(1, 1, 1'b0, stalls);
    chk("collision_stall", 32'(stalls), 32'(1));

    // TS word with scrambling disabled
    dis = 1;
    data = 32'h4A4A4ABC; datak = 4'h1; ts = 1; last = 1; valid = 1;
    acc = 0; guard = 0;
    while (!acc && guard < 4) begin cyc(); guard++; end
    chk("ts_accepted", 32'(acc), 32'(1));
    chk("ts_bypass", 32'(scr_ts), 32'hF);
    chk("ts_lfsr_reset", 32'(scr_lr), 32'(1));
    chk("ts_scr_en", 32'(scr_en), 32'(0));
    valid = 0; ts = 0; last = 0; dis = 0;
    cyc();

    // Link drop after word 3 of 6
    wait_since(1);
    send_pkt(6, 3, 1'b0, stalls);
    link = 0; valid = 1; rand_word();
    cyc();
    chk("drop_valid", 32'(scr_valid), 32'(0));
    chk("drop_ready", 32'(up_ready), 32'(0));
    cyc();
    link = 1; valid = 0;
    k = 0; guard = 0;
    while (!skp_sent && guard < 3 * N) begin cyc(); guard++; end
    chk("relink_skp_pos", 32'(guard), 32'(N));

    // Random traffic with gaps, link drops and disable toggles
    holding = 0; wi = 0; plen = $urandom_range(1, 6);
    for (int c = 0; c < 500; c++) begin
      link = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 19) == 0) dis = ~dis;
      if (!holding) begin
        valid = ($urandom_range(0, 3) != 0);
        rand_word();
        last = (wi == plen - 1);
      end
      cyc();
      if (acc) begin
        holding = 0;
        if (last) begin wi = 0; plen = $urandom_range(1, 12); end
        else wi++;
      end else begin
        holding = valid;
      end
      if (!link) begin wi = 0; holding = 0; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
